// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two write-back requesters, the issue stage and the arbiter.
// Carries the request handshakes, the register-file write port and the busy scoreboard.
interface regfile_wb_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [31:0] busy;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  rsv_en, rsv_addr,
      output req0_ready, req1_ready,
      output wr_en, wr_addr, wr_data,
      output busy
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output rsv_en, rsv_addr,
      input  req0_ready, req1_ready,
      input  wr_en, wr_addr, wr_data,
      input  busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a registered
// write stage and a per-register busy scoreboard for issue-stage stalls.
module regfile_wb_arbiter #(
   parameter logic RESET_PRIO = 1'b0
) (
   input  logic               clk,
   input  logic               reset_n,
   regfile_wb_arbiter_if.slave bus
);

   logic        prio;
   logic        gnt0;
   logic        gnt1;
   logic        grant_any;
   logic [4:0]  gnt_addr;
   logic [31:0] gnt_data;
   logic [31:0] clr_mask;
   logic [31:0] set_mask;
   logic        wr_en_q;
   logic [4:0]  wr_addr_q;
   logic [31:0] wr_data_q;
   logic [31:0] busy_q;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_n) begin
         if (bus.req0_valid && (!bus.req1_valid || !prio))
            gnt0 = 1'b1;
         else if (bus.req1_valid)
            gnt1 = 1'b1;
      end
   end

   assign grant_any = gnt0 | gnt1;
   assign gnt_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
   assign gnt_data  = gnt1 ? bus.req1_data : bus.req0_data;

   // Set is applied after clear so a same-edge re-reservation by a newer instruction wins.
   assign clr_mask = grant_any ? (32'd1 << gnt_addr) : 32'd0;
   assign set_mask = (bus.rsv_en && bus.rsv_addr != 5'd0) ? (32'd1 << bus.rsv_addr) : 32'd0;

   // NOTE: non-blocking assignments so every register samples pre-edge values together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio      <= RESET_PRIO;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 5'd0;
         wr_data_q <= 32'd0;
         busy_q    <= 32'd0;
      end else begin
         busy_q <= (busy_q & ~clr_mask) | set_mask;
         if (grant_any) begin
            prio      <= gnt0;
            wr_en_q   <= (gnt_addr != 5'd0);
            wr_addr_q <= gnt_addr;
            wr_data_q <= gnt_data;
         end else begin
            wr_en_q <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration, write stage and scoreboard.
module tb_regfile_wb_arbiter;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(.RESET_PRIO(1'b0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   int          m_prio;
   logic [31:0] m_busy;
   logic        m_wr_en;
   logic [4:0]  m_wr_addr;
   logic [31:0] m_wr_data;

   function automatic void model_reset();
      m_prio    = 0;
      m_busy    = 32'd0;
      m_wr_en   = 1'b0;
      m_wr_addr = 5'd0;
      m_wr_data = 32'd0;
   endfunction

   // Returns the requester that should win this cycle, or -1 for none.
   function automatic int model_grant();
      if (bus.req0_valid && !bus.req1_valid) return 0;
      if (bus.req1_valid && !bus.req0_valid) return 1;
      if (bus.req0_valid && bus.req1_valid)  return m_prio;
      return -1;
   endfunction

   task automatic apply(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic re, input logic [4:0] ra);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      bus.rsv_en     = re;
      bus.rsv_addr   = ra;
      #1;
   endtask

   task automatic idle();
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   // Advance one clock edge, updating the model with the inputs present at that edge.
   task automatic tick();
      int          g;
      logic [4:0]  addr;
      logic [31:0] data;
      g = model_grant();
      if (g >= 0) begin
         addr      = (g == 1) ? bus.req1_addr : bus.req0_addr;
         data      = (g == 1) ? bus.req1_data : bus.req0_data;
         m_wr_en   = (addr != 5'd0);
         m_wr_addr = addr;
         m_wr_data = data;
         m_prio    = 1 - g;
         m_busy[addr] = 1'b0;
      end else begin
         m_wr_en = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != 5'd0) m_busy[bus.rsv_addr] = 1'b1;
      m_busy[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      apply(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222, 1'b1, 5'd6);
      checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", bus.req0_ready); end
      checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", bus.req1_ready); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
      checks++; if (bus.wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", bus.wr_addr); end
      checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy); end
      idle();
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single_write();
      apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", bus.req0_ready); end
      tick();
      idle();
      checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%b exp=1", bus.wr_en); end
      checks++; if (bus.wr_addr !== 5'd5) begin failures++; $display("FAIL single_wr_addr got=%0d exp=5", bus.wr_addr); end
      checks++; if (bus.wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_wr_data got=%h exp=deadbeef", bus.wr_data); end
      tick();
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL single_wr_en_drop got=%b exp=0", bus.wr_en); end
   endtask

   task automatic test_contention();
      logic        exp0;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, 1'b0, 5'd0);
         exp0 = (i % 2 == 0);
         checks++; if (bus.req0_ready !== exp0) begin failures++; $display("FAIL contend_req0_ready[%0d] got=%b exp=%b", i, bus.req0_ready, exp0); end
         checks++; if (bus.req1_ready !== !exp0) begin failures++; $display("FAIL contend_req1_ready[%0d] got=%b exp=%b", i, bus.req1_ready, !exp0); end
         tick();
         exp_addr = exp0 ? 5'd1 : 5'd2;
         exp_data = exp0 ? 32'h100 + i : 32'h200 + i;
         checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL contend_wr_en[%0d] got=%b exp=1", i, bus.wr_en); end
         checks++; if (bus.wr_addr !== exp_addr) begin failures++; $display("FAIL contend_wr_addr[%0d] got=%0d exp=%0d", i, bus.wr_addr, exp_addr); end
         checks++; if (bus.wr_data !== exp_data) begin failures++; $display("FAIL contend_wr_data[%0d] got=%h exp=%h", i, bus.wr_data, exp_data); end
      end
      idle();
      tick();
   endtask

   task automatic test_x0_write();
      apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
      checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", bus.req1_ready); end
      tick();
      idle();
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL x0_wr_en got=%b exp=0", bus.wr_en); end
      checks++; if (bus.wr_data !== 32'h1234) begin failures++; $display("FAIL x0_wr_data got=%h exp=1234", bus.wr_data); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL x0_busy got=%h exp=0", bus.busy); end
   endtask

   task automatic test_scoreboard();
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      tick();
      checks++; if (bus.busy !== 32'h80) begin failures++; $display("FAIL sb_set got=%h exp=80", bus.busy); end
      apply(1'b1, 5'd7, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick();
      checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL sb_clear_wr_en got=%b exp=1", bus.wr_en); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL sb_clear got=%h exp=0", bus.busy); end
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      tick();
      apply(1'b1, 5'd7, 32'hA5A5_0002, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      tick();
      checks++; if (bus.busy !== 32'h80) begin failures++; $display("FAIL sb_set_wins got=%h exp=80", bus.busy); end
      apply(1'b1, 5'd7, 32'hA5A5_0003, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
      tick();
      checks++; if (bus.busy !== 32'h08) begin failures++; $display("FAIL sb_set_clear_diff got=%h exp=08", bus.busy); end
      apply(1'b1, 5'd3, 32'hA5A5_0004, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      tick();
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
      tick();
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL sb_rsv_x0 got=%h exp=0", bus.busy); end
      idle();
   endtask

   task automatic test_random();
      int g;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         g = model_grant();
         checks++; if (bus.req0_ready !== (g == 0)) begin failures++; $display("FAIL rand_req0_ready[%0d] got=%b exp=%b", i, bus.req0_ready, (g == 0)); end
         checks++; if (bus.req1_ready !== (g == 1)) begin failures++; $display("FAIL rand_req1_ready[%0d] got=%b exp=%b", i, bus.req1_ready, (g == 1)); end
         tick();
         checks++; if (bus.wr_en !== m_wr_en) begin failures++; $display("FAIL rand_wr_en[%0d] got=%b exp=%b", i, bus.wr_en, m_wr_en); end
         checks++; if (bus.wr_addr !== m_wr_addr) begin failures++; $display("FAIL rand_wr_addr[%0d] got=%0d exp=%0d", i, bus.wr_addr, m_wr_addr); end
         checks++; if (bus.wr_data !== m_wr_data) begin failures++; $display("FAIL rand_wr_data[%0d] got=%h exp=%h", i, bus.wr_data, m_wr_data); end
         checks++; if (bus.busy !== m_busy) begin failures++; $display("FAIL rand_busy[%0d] got=%h exp=%h", i, bus.busy, m_busy); end
      end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      tick();
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
      tick();
      apply(1'b1, 5'd1, 32'hCAFE_0001, 1'b1, 5'd3, 32'hCAFE_0003, 1'b0, 5'd0);
      tick();
      checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL areset_pre_wr_en got=%b exp=1", bus.wr_en); end
      checks++; if (bus.busy !== 32'h84) begin failures++; $display("FAIL areset_pre_busy got=%h exp=84", bus.busy); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL areset_wr_en got=%b exp=0", bus.wr_en); end
      checks++; if (bus.wr_addr !== 5'd0) begin failures++; $display("FAIL areset_wr_addr got=%0d exp=0", bus.wr_addr); end
      checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL areset_wr_data got=%h exp=0", bus.wr_data); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL areset_busy got=%h exp=0", bus.busy); end
      checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL areset_req0_ready got=%b exp=0", bus.req0_ready); end
      checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL areset_req1_ready got=%b exp=0", bus.req1_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBEEF_0009, 1'b0, 5'd0);
      checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL release_req1_ready got=%b exp=1", bus.req1_ready); end
      tick();
      checks++; if (bus.wr_addr !== 5'd9) begin failures++; $display("FAIL release_wr_addr got=%0d exp=9", bus.wr_addr); end
      apply(1'b1, 5'd4, 32'hBEEF_0004, 1'b1, 5'd5, 32'hBEEF_0005, 1'b0, 5'd0);
      checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL release_prio got=%b exp=1", bus.req0_ready); end
      tick();
      checks++; if (bus.wr_addr !== 5'd4) begin failures++; $display("FAIL release_wr_addr2 got=%0d exp=4", bus.wr_addr); end
      idle();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      test_reset();
      test_single_write();
      test_contention();
      test_x0_write();
      test_scoreboard();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and destination scoreboard for `register32bit_file`. It shares the register file's single write port between two write-back requesters:

- req0: ALU result path.
- req1: load/CSR path.

It uses a valid/ready handshake with round-robin priority and drives `reg_if.wr_en`/`wr_addr`/`wr_data` from registers. It also keeps a 32-bit busy scoreboard, so issue logic can stall on a destination register that still has a write in flight.

## Interface

Parameters:
- `RESET_PRIO`, default 0: requester that holds priority after reset (0 or 1).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  req0 offers a write.
- `req0_ready`  out  1  req0 write accepted this cycle (combinational).
- `req0_addr`  in  5  req0 destination register.
- `req0_data`  in  32  req0 write data.
- `req1_valid`  in  1  req1 offers a write.
- `req1_ready`  out  1  req1 write accepted this cycle (combinational).
- `req1_addr`  in  5  req1 destination register.
- `req1_data`  in  32  req1 write data.
- `wr_en`  out  1  registered; drives `reg_if.wr_en`.
- `wr_addr`  out  5  registered; drives `reg_if.wr_addr`.
- `wr_data`  out  32  registered; drives `reg_if.wr_data`.
- `rsv_en`  in  1  issue stage reserves a destination register.
- `rsv_addr`  in  5  register being reserved.
- `busy`  out  32  scoreboard; bit i = write to register i pending.

## Operation

Arbitration:
- `prio` is a 1-bit round-robin pointer.
- Only req0 valid: grant 0. Only req1 valid: grant 1. Both valid: grant `prio`. Neither valid: no grant.
- `reqN_ready` = grant N and `reset_n` high. Ready is never asserted without the matching valid.
- Requesters keep addr/data stable while valid and not ready. The block does not check this.

Priority update:
- After any grant, `prio` moves to the non-granted requester. This happens even without contention.
- With no grant, `prio` holds.

Write stage:
- On a granted edge: `wr_en` <= 1 if the granted addr != 0, else 0. `wr_addr`/`wr_data` <= the granted addr/data.
- With no grant: `wr_en` <= 0; `wr_addr`/`wr_data` hold.
- A write to x0 is accepted (ready=1) and discarded. It produces no `wr_en` pulse and has no busy effect.

Scoreboard (`busy`):
- Set: on `rsv_en` with `rsv_addr` != 0, bit `rsv_addr` <= 1.
- Clear: on a granted acceptance, bit (granted addr) <= 0. The bit falls on the same edge `wr_en` rises.
- Set and clear of the same bit on the same edge: set wins, because a newer instruction has reserved it.
- Set and clear of different bits on the same edge: both take effect.
- Re-reserving an already-busy bit: no change. No overlap count is kept.
- `busy[0]` is constant 0.

## Timing

- Request to register-file write: 1 cycle. A grant at edge k gives `wr_*` valid during cycle k+1; the register file captures it at edge k+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate 0,1,0,1,...
- Ready depends combinationally on valid and `prio` only. There is no combinational path from `wr_*` or `busy` to ready.

Reset (`reset_n` low, asynchronous, any time, including mid-operation):
- `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `prio`=`RESET_PRIO`.
- `req0_ready`=`req1_ready`=0 while reset is held.
- A write pending in the output registers is dropped and its busy bit is cleared.
- First grant is possible on the first rising edge after `reset_n` deasserts.

## Test plan

- Reset, then req0 valid with addr 5, data 0xDEADBEEF:
  - cycle 0: `req0_ready`=1.
  - cycle 1: `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF.
  - cycle 2: `wr_en`=0.
- Both valid for 4 cycles, req0 addr 1 and req1 addr 2, `RESET_PRIO`=0:
  - grants 0,1,0,1.
  - `wr_addr` sequence 1,2,1,2 with `wr_en` held at 1.
- req1 valid, addr 0, data 0x1234: `req1_ready`=1, then `wr_en` stays 0 and `busy` stays 0.
- Scoreboard sequence:
  - `rsv_en` addr 7: `busy[7]`=1 next cycle.
  - req0 write to 7 accepted: `busy[7]`=0 on the same edge `wr_en` rises.
  - `rsv_en` addr 7 on the same edge as a write to 7 is accepted: `busy[7]` remains 1.
  - `rsv_en` addr 0: `busy` stays 0.
- Reset asserted mid-burst, with `wr_en`=1 and `busy`=0x0000_0084: all outputs clear immediately, without waiting for `clk`. After release with req1 only valid, the grant goes to req1 and `prio` moves to 0.
